// File: rtl/neuron_step_ctrl.sv
// neuron_step_ctrl: sequencer for the 21-bit Izhikevich neuron datapath.
// Replays a stimulus table into neu_I, one entry per evaluation step.
// It samples the step-final membrane potential, re-initialises the datapath
// after a spike, and reports spike events and a saturating spike count.
// Optional feature macro: NEU_TRACE_EN adds trace_valid/trace_v outputs that
// report the sampled v once per completed step.
module neuron_step_ctrl #(
    parameter int unsigned        DEPTH    = 16,
    parameter int unsigned        AW       = 4,
    parameter int unsigned        STEP_CYC = 8,
    parameter logic signed [20:0] SPIKE_TH = 21'sh0F000,
    parameter int unsigned        CNT_W    = 8
) (
    input  logic             clk,
    input  logic             set_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [20:0]      cfg_data,
    input  logic [AW:0]      n_steps,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             neu_set,
    output logic [20:0]      neu_I,
    input  logic [20:0]      neu_final,
    output logic             spike_valid,
    output logic [AW-1:0]    spike_step,
    output logic [20:0]      spike_v,
    output logic [CNT_W-1:0] spike_cnt
`ifdef NEU_TRACE_EN
    ,
    output logic             trace_valid,
    output logic [20:0]      trace_v
`endif
);

    localparam int unsigned CW = $clog2(STEP_CYC + 1);
    // cyc counts 0..STEP_CYC-1 through the datapath step, STEP_CYC is the evaluate cycle
    localparam logic [CW-1:0] CYC_SMP = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] CYC_EVL = CW'(STEP_CYC);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_SPK, S_DONE} state_t;

    state_t             state_q;
    logic [AW:0]        nsteps_q;
    logic [AW-1:0]      step_q;
    logic [CW-1:0]      cyc_q;
    logic signed [20:0] vs_q;
    logic [20:0]        tbl_q [DEPTH];

    logic               busy_w;
    logic [AW:0]        step_inc;
    logic [AW-1:0]      step_nxt;
    logic               last_step;

    assign busy_w    = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_SPK);
    assign busy      = busy_w;
    assign step_inc  = {1'b0, step_q} + {{AW{1'b0}}, 1'b1};
    assign step_nxt  = step_q + {{(AW-1){1'b0}}, 1'b1};
    assign last_step = (step_inc == nsteps_q);

    // Stimulus table: host writes are accepted only while no run is active
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_w) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    // Run sequencer with registered datapath controls and host-side reports
    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state_q     <= S_IDLE;
            nsteps_q    <= '0;
            step_q      <= '0;
            cyc_q       <= '0;
            vs_q        <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            neu_set     <= 1'b1;
            neu_I       <= '0;
            spike_valid <= 1'b0;
            spike_step  <= '0;
            spike_v     <= '0;
            spike_cnt   <= '0;
`ifdef NEU_TRACE_EN
            trace_valid <= 1'b0;
            trace_v     <= '0;
`endif
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            cfg_err     <= cfg_we && busy_w;
`ifdef NEU_TRACE_EN
            trace_valid <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    neu_set <= 1'b1;
                    if (start && !abort) begin
                        nsteps_q  <= n_steps;
                        spike_cnt <= '0;
                        if (n_steps == '0) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q <= S_INIT;
                            step_q  <= '0;
                            cyc_q   <= '0;
                            neu_I   <= tbl_q[0];
                        end
                    end
                end
                S_INIT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        neu_set <= 1'b1;
                    end else if (cyc_q != '0) begin
                        state_q <= S_RUN;
                        cyc_q   <= '0;
                        neu_set <= 1'b0;
                    end else begin
                        cyc_q <= CW'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        neu_set <= 1'b1;
                    end else if (cyc_q == CYC_EVL) begin
`ifdef NEU_TRACE_EN
                        trace_valid <= 1'b1;
                        trace_v     <= vs_q;
`endif
                        if (vs_q >= SPIKE_TH) begin
                            state_q     <= S_SPK;
                            neu_set     <= 1'b1;
                            spike_valid <= 1'b1;
                            spike_step  <= step_q;
                            spike_v     <= vs_q;
                            if (spike_cnt != '1) begin
                                spike_cnt <= spike_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else if (last_step) begin
                            state_q <= S_DONE;
                            neu_set <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            step_q <= step_nxt;
                            cyc_q  <= '0;
                            neu_I  <= tbl_q[step_nxt];
                        end
                    end else begin
                        if (cyc_q == CYC_SMP) begin
                            vs_q <= neu_final;
                        end
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                S_SPK: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (last_step) begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        neu_set <= 1'b0;
                        step_q  <= step_nxt;
                        cyc_q   <= '0;
                        neu_I   <= tbl_q[step_nxt];
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    neu_set <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    neu_set <= 1'b1;
                end
            endcase
        end
    end

endmodule
